conv_window_sequencer: RTL and testbench

Controller that sequences one convolution pass over a switch-loaded binary image. It accepts a 6x6 image one row at a time and presents each 3x3 window, in raster order, to a shared downstream MAC/kernel unit over a valid/ready handshake. It collects the MAC results into a 4x4 result buffer and streams them out with backpressure. It sits between the switch-row capture logic and the convolution datapath, and owns all pass-level sequencing.

---
 rtl/conv_window_sequencer.sv | 143 ++++++++++++++
 tb/tb_conv_window_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// Sequences one convolution pass: captures a 6x6 binary image, issues 3x3 windows to a MAC, drains the 4x4 results.
// Latency: start->first row 1 cycle, 2 cycles per window (issue + result), 1 cycle per drained result; 55 cycles minimum.
// Backpressure: row_ready only in LOAD, windows held until win_ready, results held until out_ready; WAIT stalls on res_valid.
module conv_window_sequencer #(
  parameter int IMG = 6,
  parameter int K = 3,
  parameter int RW = 8,
  localparam int OUT = IMG - K + 1,
  localparam int NWIN = OUT * OUT,
  localparam int IW = $clog2(NWIN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           row_valid,
  input  logic [IMG-1:0] row_data,
  output logic           row_ready,
  output logic           win_valid,
  output logic [K*K-1:0] win_data,
  output logic [IW-1:0]  win_idx,
  input  logic           win_ready,
  input  logic           res_valid,
  input  logic [RW-1:0]  res_data,
  output logic           out_valid,
  output logic [RW-1:0]  out_data,
  output logic [IW-1:0]  out_idx,
  input  logic           out_ready,
  output logic           busy,
  output logic           done
);

  // Pixel addressing width and row counter width (counter must reach IMG).
  localparam int AW  = $clog2(IMG);
  localparam int RCW = $clog2(IMG + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]     state;
  logic [RCW-1:0] row_cnt;
  logic [IW-1:0]  win_cnt;
  logic [IW-1:0]  out_cnt;

  // Image and result storage; every entry is rewritten before it is read in a pass, so no reset.
  logic [IMG-1:0] img    [IMG];
  logic [RW-1:0]  result [NWIN];

  // Window origin decoded from the raster window counter.
  logic [AW-1:0] wr;
  logic [AW-1:0] wc;
  assign wr = AW'(int'(win_cnt) / OUT);
  assign wc = AW'(int'(win_cnt) % OUT);

  // Pass-level FSM and counters; done is a registered one-cycle pulse on the final drain handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      win_cnt <= '0;
      out_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            row_cnt <= '0;
            win_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (row_valid) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == RCW'(IMG - 1)) begin
              state   <= S_ISSUE;
              win_cnt <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (win_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (res_valid) begin
            if (win_cnt == IW'(NWIN - 1)) begin
              state   <= S_DRAIN;
              out_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              state   <= S_ISSUE;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_cnt == IW'(NWIN - 1)) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Row capture during LOAD; row_ready is exactly the LOAD state so the handshake reduces to row_valid.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_LOAD && row_valid) img[row_cnt[AW-1:0]] <= row_data;
  end

  // Result capture only while waiting on the MAC; res_valid elsewhere is ignored.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_WAIT && res_valid) result[win_cnt] <= res_data;
  end

  // Window extraction, forced to zero outside ISSUE so idle outputs are clean.
  always_comb begin
    win_data = '0;
    if (state == S_ISSUE) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_data[r*K+c] = img[AW'(int'(wr) + r)][AW'(int'(wc) + c)];
        end
      end
    end
  end

  assign row_ready = (state == S_LOAD);
  assign win_valid = (state == S_ISSUE);
  assign win_idx   = (state == S_ISSUE) ? win_cnt : '0;
  assign out_valid = (state == S_DRAIN);
  assign out_data  = (state == S_DRAIN) ? result[out_cnt] : '0;
  assign out_idx   = (state == S_DRAIN) ? out_cnt : '0;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: MAC/consumer models drive the handshakes, a pass-level model checks every cycle.
// Latency: pass length pinned for the ideal case; results pinned against hand-computed popcount images.
// Backpressure: stalled windows/results must hold their values until accepted.
module tb_conv_window_sequencer;
  localparam int IMG = 6;
  localparam int K = 3;
  localparam int RW = 8;
  localparam int OUT = 4;
  localparam int NWIN = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start, row_valid, row_ready;
  logic [IMG-1:0] row_data;
  logic           win_valid, win_ready, res_valid, out_valid, out_ready, busy, done;
  logic [K*K-1:0] win_data;
  logic [IW-1:0]  win_idx, out_idx;
  logic [RW-1:0]  res_data, out_data;

  conv_window_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
    .win_valid(win_valid), .win_data(win_data), .win_idx(win_idx), .win_ready(win_ready),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment knobs
  int win_stall = 0;
  int res_delay = 0;
  bit out_tog = 0;
  bit spur_res = 0;

  function automatic int popc(input logic [8:0] v);
    int n = 0;
    for (int i = 0; i < 9; i++) n += int'(v[i]);
    return n;
  endfunction

  // Window bits straight from the definition: bit r*K+c = pixel[wr+r][wc+c]
  function automatic logic [8:0] win_model(input logic [IMG-1:0][IMG-1:0] im, input int idx);
    logic [8:0] w = '0;
    int wr = idx / OUT;
    int wc = idx % OUT;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[r*K+c] = im[wr+r][wc+c];
    return w;
  endfunction

  // MAC model: returns popcount(win_data) after res_delay cycles, optionally stalls and injects bogus results.
  initial begin : mac
    int ph, st, dl;
    logic [RW-1:0] pend;
    ph = 0; st = 0; dl = 0; pend = '0;
    win_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    forever begin
      @(posedge clk); #2;
      res_valid = 1'b0;
      if (!rst_n) begin
        ph = 0; st = 0; dl = 0; win_ready = 1'b0;
      end else if (ph == 1) begin
        win_ready = 1'b0;
        if (dl < res_delay) dl++;
        else begin res_valid = 1'b1; res_data = RW'(pend); dl = 0; ph = 2; end
      end else begin
        ph = 0;
        if (win_valid) begin
          if (st < win_stall) begin
            win_ready = 1'b0; st++;
            if (spur_res) begin res_valid = 1'b1; res_data = 8'hEE; end
          end else begin
            win_ready = 1'b1; pend = RW'(popc(win_data)); st = 0; ph = 1;
          end
        end else win_ready = 1'b0;
      end
    end
  end

  // Result consumer: always ready, or toggling 1010
  initial begin : consumer
    bit t;
    t = 1'b1;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (out_tog) begin out_ready = t; t = ~t; end
      else out_ready = 1'b1;
    end
  end

  // Pass-level model: image rows, windows accepted, results returned, results drained
  logic [IMG-1:0][IMG-1:0] m_img;
  logic [RW-1:0] m_result [NWIN];
  int m_rows = 0, m_acc = 0, m_res = 0, m_outs = 0, done_cnt = 0;
  bit in_pass = 0, exp_done = 0, mon_en = 0;
  logic [RW-1:0] outq[$];

  initial begin : monitor
    bit computing, draining, outst, ws, os;
    logic [8:0] ws_d;
    logic [IW-1:0] ws_i, os_i;
    logic [RW-1:0] os_d;
    ws = 0; os = 0; ws_d = '0; ws_i = '0; os_i = '0; os_d = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        computing = in_pass && m_rows == IMG && m_res < NWIN;
        draining  = in_pass && m_res == NWIN;
        outst     = m_acc > m_res;
        chk("busy", int'(busy), int'(in_pass));
        chk("row_ready", int'(row_ready), int'(in_pass && m_rows < IMG));
        chk("win_valid", int'(win_valid), int'(computing && !outst));
        chk("out_valid", int'(out_valid), int'(draining));
        chk("done", int'(done), int'(exp_done));
        if (done) done_cnt++;
        if (win_valid && m_res < NWIN) begin
          chk("win_idx", int'(win_idx), m_res);
          chk("win_data", int'(win_data), int'(win_model(m_img, m_res)));
        end
        if (ws) begin
          chk("win_hold_data", int'(win_data), int'(ws_d));
          chk("win_hold_idx", int'(win_idx), int'(ws_i));
        end
        if (os) begin
          chk("out_hold_data", int'(out_data), int'(os_d));
          chk("out_hold_idx", int'(out_idx), int'(os_i));
        end
        ws = win_valid && !win_ready && rst_n; ws_d = win_data; ws_i = win_idx;
        os = out_valid && !out_ready && rst_n; os_d = out_data; os_i = out_idx;
        if (out_valid && m_outs < NWIN) begin
          chk("out_idx", int'(out_idx), m_outs);
          chk("out_data", int'(out_data), int'(m_result[m_outs]));
        end
        // advance the model across the coming edge
        exp_done = 0;
        if (!rst_n) begin
          in_pass = 0; m_rows = 0; m_acc = 0; m_res = 0; m_outs = 0;
        end else if (!in_pass) begin
          if (start) begin in_pass = 1; m_rows = 0; m_acc = 0; m_res = 0; m_outs = 0; end
        end else if (m_rows < IMG) begin
          if (row_valid) begin m_img[m_rows] = row_data; m_rows++; end
        end else if (m_res < NWIN) begin
          if (outst) begin
            if (res_valid) begin m_result[m_res] = res_data; m_res++; end
          end else if (win_ready) m_acc++;
        end else if (out_ready) begin
          outq.push_back(out_data);
          m_outs++;
          if (m_outs == NWIN) begin in_pass = 0; exp_done = 1; end
        end
      end
    end
  end

  int c0;
  int exp_ck [NWIN] = '{5,4,5,4, 4,5,4,5, 5,4,5,4, 4,5,4,5};
  logic [IMG-1:0][IMG-1:0] ones_img, ck_img;

  // Start a pass and feed six rows; optional gaps, spurious start in LOAD, and a lingering 7th row.
  task automatic send_rows(input logic [IMG-1:0][IMG-1:0] rows, input int gap, input bit spur, input bit extra);
    bit acc;
    outq.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < IMG; i++) begin
      int g;
      g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      row_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      row_valid = 1'b1; row_data = rows[i];
      if (spur && i == 2) start = 1'b1;
      acc = 0;
      for (int t = 0; t < 50 && !acc; t++) begin
        acc = row_ready;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (!acc) chk("row_accept_timeout", 0, 1);
    end
    if (extra) begin row_valid = 1'b1; row_data = 6'h00; end
    else row_valid = 1'b0;
  endtask

  // Optional spurious starts in ISSUE and DRAIN, then wait for done and return the pass length.
  task automatic finish_pass(input bit spur, output int cycles);
    bit seen;
    if (spur) begin
      seen = 0;
      for (int t = 0; t < 200 && !seen; t++) begin
        if (win_valid) seen = 1; else begin @(posedge clk); #1; end
      end
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      seen = 0;
      for (int t = 0; t < 3000 && !seen; t++) begin
        if (out_valid && out_idx == 4'd3) seen = 1; else begin @(posedge clk); #1; end
      end
      if (!seen) chk("drain_timeout", 0, 1);
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
    end
    seen = 0;
    for (int t = 0; t < 4000 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    cycles = cyc - c0;
    @(posedge clk); #1;
    row_valid = 1'b0;
  endtask

  task automatic check_outs(input string name, input bit ones);
    chk({name, "_count"}, outq.size(), NWIN);
    for (int i = 0; i < NWIN && i < outq.size(); i++)
      chk(name, int'(outq[i]), ones ? 9 : exp_ck[i]);
    chk({name, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin : main
    int cycles;
    bit seen;
    for (int r = 0; r < IMG; r++) begin
      ones_img[r] = 6'h3F;
      ck_img[r] = (r % 2 == 0) ? 6'h15 : 6'h2A;
    end
    rst_n = 1'b0; start = 1'b0; row_valid = 1'b0; row_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_row_ready", int'(row_ready), 0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_win_data", int'(win_data), 0);
    chk("rst_win_idx", int'(win_idx), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    mon_en = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All-ones image, ideal MAC
    send_rows(ones_img, 0, 0, 0);
    finish_pass(0, cycles);
    check_outs("ones_ideal", 1);
    chk("pass_cycles", cycles, 55);

    // Checkerboard, ideal MAC; first window pinned by hand
    send_rows(ck_img, 0, 0, 0);
    chk("ck_win0_data", int'(win_data), int'(9'b101010101));
    chk("ck_win0_idx", int'(win_idx), 0);
    finish_pass(0, cycles);
    check_outs("ck_ideal", 0);

    // Checkerboard with stalls and backpressure
    win_stall = 3; res_delay = 2; out_tog = 1;
    send_rows(ck_img, 0, 0, 0);
    finish_pass(0, cycles);
    check_outs("ck_stall", 0);

    // Spurious starts and res_valid pulses in ISSUE
    win_stall = 2; res_delay = 0; out_tog = 0; spur_res = 1;
    send_rows(ck_img, 0, 1, 0);
    finish_pass(1, cycles);
    check_outs("ck_spur", 0);
    win_stall = 0; spur_res = 0;

    // Reset during WAIT at window 7
    res_delay = 1;
    send_rows(ones_img, 0, 0, 0);
    seen = 0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      if (win_valid && win_ready && win_idx == 4'd7) seen = 1;
    end
    if (!seen) chk("win7_timeout", 0, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_win_valid", int'(win_valid), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_row_ready", int'(row_ready), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_win_idx", int'(win_idx), 0);
    chk("mid_rst_win_data", int'(win_data), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    res_delay = 0;
    send_rows(ones_img, 0, 0, 0);
    finish_pass(0, cycles);
    check_outs("after_rst", 1);

    // Random row gaps plus a 7th row held valid that must not be taken
    send_rows(ones_img, 4, 0, 1);
    chk("row7_ready", int'(row_ready), 0);
    finish_pass(0, cycles);
    check_outs("row_gaps", 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
